// File: rtl/conv_layer_sequencer_if.sv
// Pixel-in / result-out valid/ready bundle for conv_layer_sequencer.
interface conv_layer_sequencer_if #(
  parameter int D_BITS = 16,
  parameter int Q_BITS = 16
);
  logic [D_BITS-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [Q_BITS-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Frame sequencer feeding convolutional_layer; tags in-image windows.
// CONV_SEQ_AUTO_RESTART_EN: DONE re-enters STREAM without a new start.
module conv_layer_sequencer #(
  parameter int D_WIDTH       = 8,
  parameter int D_CHANNELS    = 2,
  parameter int Q_WIDTH       = 16,
  parameter int Q_CHANNELS    = 1,
  parameter int FILTER_SIZE   = 2,
  parameter int IMAGE_SIZE    = 64,
  parameter int LAYER_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  conv_layer_sequencer_if.slave bus,
  output logic layer_clk_en,
  output logic [D_CHANNELS*D_WIDTH-1:0] layer_input_data,
  input  logic [Q_CHANNELS*Q_WIDTH-1:0] layer_output_data,
  output logic busy,
  output logic frame_done
);
  localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int FW = (LAYER_LATENCY > 1) ? $clog2(LAYER_LATENCY) : 1;
  localparam logic [CW-1:0] LAST  = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] FM1   = CW'(FILTER_SIZE - 1);
  localparam logic [FW-1:0] FLAST = FW'(LAYER_LATENCY - 1);
`ifdef CONV_SEQ_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, STREAM, FLUSH, DONE
  } state_t;

  state_t r_state;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [FW-1:0] r_flush;
  logic r_out_valid;
  logic r_frame_done;

  logic w_stage_free;
  logic w_flush_done;
  logic w_adv;
  logic w_acc;
  logic w_clr;
  logic w_last;
  logic [LAYER_LATENCY-1:0] w_chain;

  assign w_stage_free = bus.out_ready || !r_out_valid;
  assign w_flush_done = (r_flush == FLAST);
  assign w_acc  = (r_state == STREAM) && w_adv;
  assign w_last = (r_row == LAST) && (r_col == LAST);
  assign w_clr  = ((r_state == IDLE) && start)
               || ((r_state == DONE) && AUTO);

  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      STREAM:  w_adv = w_stage_free && bus.in_valid;
      FLUSH:   w_adv = w_stage_free && !w_flush_done;
      default: w_adv = 1'b0;
    endcase
  end

  // chain[0] is the tag entering the layer; chain[top] feeds out_valid
  assign w_chain[0] = w_acc && (r_row >= FM1) && (r_col >= FM1);

  generate
    if (LAYER_LATENCY > 1) begin : g_pipe
      logic [LAYER_LATENCY-2:0] r_pipe;
      assign w_chain[LAYER_LATENCY-1:1] = r_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else if (w_clr) begin
          r_pipe <= '0;
        end else if (w_adv) begin
          r_pipe <= w_chain[LAYER_LATENCY-2:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_flush      <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_adv) begin
        r_out_valid <= w_chain[LAYER_LATENCY-1];
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        STREAM: begin
          if (w_acc) begin
            if (r_col == LAST) begin
              r_col <= '0;
              r_row <= r_row + CW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_last) begin
              r_state <= FLUSH;
              r_flush <= '0;
            end
          end
        end
        FLUSH: begin
          if (w_flush_done && w_stage_free) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end else if (w_adv) begin
            r_flush <= r_flush + FW'(1);
          end
        end
        DONE: begin
          r_state <= AUTO ? STREAM : IDLE;
          r_row   <= '0;
          r_col   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == STREAM) && w_stage_free;
  assign bus.out_valid = r_out_valid;
  // gated so the result bus reads zero whenever nothing is offered
  assign bus.out_data  = r_out_valid ? layer_output_data : '0;
  assign layer_clk_en  = w_adv;
  assign layer_input_data = (r_state == STREAM) ? bus.in_data : '0;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer with a 2x2 summing layer stub.
module tb_conv_layer_sequencer;
  localparam int IS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic layer_clk_en;
  logic busy;
  logic frame_done;
  logic [15:0] layer_input_data;
  logic [15:0] lay_out = '0;

  always #5 clk = ~clk;

  conv_layer_sequencer_if #(.D_BITS(16), .Q_BITS(16)) bus ();

  conv_layer_sequencer #(
    .D_WIDTH(8), .D_CHANNELS(2), .Q_WIDTH(16), .Q_CHANNELS(1),
    .FILTER_SIZE(2), .IMAGE_SIZE(IS), .LAYER_LATENCY(1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .layer_clk_en(layer_clk_en),
    .layer_input_data(layer_input_data),
    .layer_output_data(lay_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_fd  = 0;
  bit chk_clk = 1'b0;
  int q[$];
  int hist[5];
  int px;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // layer stub: registered 2x2 sum of both channels, advances on clk_en
  always @(posedge clk) begin
    if (layer_clk_en) begin
      px = int'(layer_input_data[15:8]) + int'(layer_input_data[7:0]);
      lay_out <= 16'(px + hist[0] + hist[IS-1] + hist[IS]);
      hist[0] <= px;
      for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_acc++;
        chk("sb_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) chk("out_data", int'(bus.out_data), q.pop_front());
      end
      if (frame_done) n_fd++;
      if (bus.in_valid && bus.in_ready)
        chk("layer_in", int'(layer_input_data), int'(bus.in_data));
      if (chk_clk)
        chk("clk_en", int'(layer_clk_en), int'(bus.in_valid && bus.in_ready));
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps,
                            input int npix, input int st_at);
    int pix[16];
    bit acc;
    for (int p = 0; p < 16; p++) pix[p] = base + p;
    for (int p = 0; p < npix; p++) begin
      int r = p / IS;
      int c = p % IS;
      acc = 1'b0;
      bus.in_data  = {8'(pix[p]), 8'h00};
      bus.in_valid = 1'b1;
      if (p == st_at) start = 1'b1;
      for (int t = 0; t < 60 && !acc; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          acc = 1'b1;
          if (r >= 1 && c >= 1)
            q.push_back(pix[p] + pix[p-1] + pix[p-IS] + pix[p-IS-1]);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("accept", int'(acc), 1);
      if (!acc) break;
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int fd0);
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("fd_seen", int'(seen), 1);
    @(posedge clk); #1;
    chk("fd_once", n_fd - fd0, 1);
    chk("n_out", n_acc - n0, 9);
    chk("sb_left", q.size(), 0);
    chk("busy_fall", int'(busy), 0);
  endtask

  task automatic bp_stall(input int n0);
    bit f = 1'b0;
    logic [15:0] held;
    for (int t = 0; t < 200 && !f; t++) begin
      @(posedge clk); #2;
      if (bus.out_valid && (n_acc - n0 == 2)) f = 1'b1;
    end
    chk("bp_found", int'(f), 1);
    if (f) begin
      held = bus.out_data;
      bus.out_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_clk_en", int'(layer_clk_en), 0);
        chk("bp_hold", int'(bus.out_data), int'(held));
      end
      @(posedge clk); #2;
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_clk_en"}, int'(layer_clk_en), 0);
    chk({tag, "_layer_in"}, int'(layer_input_data), 0);
    chk({tag, "_fd"}, int'(frame_done), 0);
  endtask

  initial begin
    int n0;
    int fd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    zero_checks("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef CONV_SEQ_AUTO_RESTART_EN
    n0 = n_acc; fd0 = n_fd;
    do_start();
    send_frame(1, 1'b0, 16, -1);
    send_frame(40, 1'b0, 16, -1);
    for (int t = 0; t < 100 && (n_fd - fd0) < 2; t++) @(posedge clk);
    #1;
    chk("fd_twice", n_fd - fd0, 2);
    chk("n_out2", n_acc - n0, 18);
    chk("sb_left", q.size(), 0);
`else
    n0 = n_acc; fd0 = n_fd;
    do_start();
    chk("busy_rise", int'(busy), 1);
    send_frame(1, 1'b0, 16, -1);
    wait_done(n0, fd0);

    n0 = n_acc; fd0 = n_fd;
    do_start();
    fork
      send_frame(21, 1'b0, 16, -1);
      bp_stall(n0);
    join
    wait_done(n0, fd0);

    n0 = n_acc; fd0 = n_fd;
    do_start();
    chk_clk = 1'b1;
    send_frame(1, 1'b1, 16, -1);
    wait_done(n0, fd0);
    chk_clk = 1'b0;

    do_start();
    send_frame(60, 1'b0, 7, -1);
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    zero_checks("mid_rst");
    q.delete();
    fd0 = n_fd;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_fd_after_rst", n_fd - fd0, 0);
    n0 = n_acc; fd0 = n_fd;
    do_start();
    send_frame(90, 1'b0, 16, -1);
    wait_done(n0, fd0);

    n0 = n_acc; fd0 = n_fd;
    do_start();
    send_frame(120, 1'b0, 16, 5);
    wait_done(n0, fd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
